// File: rtl/sdram_refresh_executor_if.sv
// sdram_refresh_executor_if: request handshake and SDRAM command pins of the refresh executor
interface sdram_refresh_executor_if;
    logic refresh_req_i;
    logic access_busy_i;
    logic banks_open_i;
    logic sdram_ready_o;
    logic cmd_own_o;
    logic sdram_cs_n_o;
    logic sdram_ras_n_o;
    logic sdram_cas_n_o;
    logic sdram_we_n_o;
    logic sdram_a10_o;
    logic refresh_done_o;
    logic overflow_o;
    modport slave (
        input  refresh_req_i, access_busy_i, banks_open_i,
        output sdram_ready_o, cmd_own_o, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o,
        output sdram_we_n_o, sdram_a10_o, refresh_done_o, overflow_o
    );
    modport master (
        output refresh_req_i, access_busy_i, banks_open_i,
        input  sdram_ready_o, cmd_own_o, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o,
        input  sdram_we_n_o, sdram_a10_o, refresh_done_o, overflow_o
    );
endinterface

// File: rtl/sdram_refresh_executor.sv
// sdram_refresh_executor: queues refresh requests and drives PRECHARGE ALL / AUTO REFRESH with tRP/tRFC spacing
module sdram_refresh_executor #(
    parameter int T_RP_CYCLES   = 2,
    parameter int T_RFC_CYCLES  = 7,
    parameter int REFRESH_BURST = 1
) (
    input logic HCLK,
    input logic HRESET,
    sdram_refresh_executor_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC, DONE} state_t;
    localparam int T_MAX = T_RP_CYCLES > T_RFC_CYCLES ? T_RP_CYCLES : T_RFC_CYCLES;
    localparam int WW = $clog2(T_MAX + 1);
    localparam logic [WW-1:0] RP_LOAD = WW'(T_RP_CYCLES - 1);
    localparam logic [WW-1:0] RFC_LOAD = WW'(T_RFC_CYCLES - 1);
    // A burst of 8 wraps the 3-bit counter to 0, so the end marker wraps with it.
    localparam logic [2:0] BURST_END = 3'(REFRESH_BURST);
    state_t state, next;
    logic [3:0] pending;
    logic [2:0] burst_cnt;
    logic [WW-1:0] wait_cnt;
    logic overflow;
    logic go, inc, dec;
    logic [4:0] cmd;
    assign go  = (pending != 4'd0 || bus.refresh_req_i) && !bus.access_busy_i;
    assign dec = state == IDLE && go;
    assign inc = bus.refresh_req_i && (pending != 4'hf || dec);
    // state register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else        state <= next;
    end
    // next-state logic; access_busy_i only matters while idle
    always_comb begin
        next = state;
        case (state)
            IDLE:      if (go) next = bus.banks_open_i ? PRECHARGE : REFRESH;
            PRECHARGE: next = T_RP_CYCLES > 1 ? WAIT_RP : REFRESH;
            WAIT_RP:   if (wait_cnt == WW'(1)) next = REFRESH;
            REFRESH:   next = WAIT_RFC;
            WAIT_RFC:  if (wait_cnt == WW'(1)) next = burst_cnt != BURST_END ? REFRESH : DONE;
            DONE:      next = IDLE;
            default:   next = IDLE;
        endcase
    end
    // request queue, sticky overflow, burst and spacing counters
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pending   <= 4'd0;
            overflow  <= 1'b0;
            burst_cnt <= 3'd0;
            wait_cnt  <= '0;
        end else begin
            pending   <= pending + 4'(inc) - 4'(dec);
            overflow  <= overflow | (bus.refresh_req_i && pending == 4'hf && !dec);
            burst_cnt <= dec ? 3'd0 : state == REFRESH ? burst_cnt + 3'd1 : burst_cnt;
            wait_cnt  <= state == PRECHARGE ? RP_LOAD :
                         state == REFRESH   ? RFC_LOAD :
                         wait_cnt != '0     ? wait_cnt - WW'(1) : wait_cnt;
        end
    end
    // command decode {cs_n, ras_n, cas_n, we_n, a10} from registered state
    always_comb begin
        cmd = state == PRECHARGE ? 5'b00101 :
              state == REFRESH   ? 5'b00010 :
              (state == WAIT_RP || state == WAIT_RFC) ? 5'b01110 : 5'b11110;
    end
    assign {bus.sdram_cs_n_o, bus.sdram_ras_n_o, bus.sdram_cas_n_o, bus.sdram_we_n_o, bus.sdram_a10_o} = cmd;
    assign bus.cmd_own_o      = state != IDLE && state != DONE;
    assign bus.refresh_done_o = state == DONE;
    assign bus.overflow_o     = overflow;
    assign bus.sdram_ready_o  = state == IDLE && pending == 4'd0 && !bus.access_busy_i;
endmodule
